// File: rtl/flag_pkg.sv
// Shared types and constants for the flag register controller.
// Flag word layout is {N,V,Z}; source encoding tags which requester owns a commit.
package flag_pkg;

    localparam int FLAG_W = 3;
    localparam int ZF     = 0;
    localparam int VF     = 1;
    localparam int NF     = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_DBG = 1'b1
    } src_t;

    function automatic logic [FLAG_W-1:0] merge_flags(
        input logic [FLAG_W-1:0] old_v,
        input logic [FLAG_W-1:0] flags_v,
        input logic [FLAG_W-1:0] mask_v
    );
        return (old_v & ~mask_v) | (flags_v & mask_v);
    endfunction

endpackage

// File: rtl/flag_arb.sv
// ALU-vs-debug arbiter: ALU wins unless debug has been starved STARVE_LIMIT cycles.
// Latency: combinational grant; starvation counter updates each rising edge.
// Backpressure: grants only while the controller is idle; the loser keeps its req held.
module flag_arb import flag_pkg::*; #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic alu_req,
    input  logic dbg_req,
    output logic grant_alu,
    output logic grant_dbg
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved   = (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign grant_dbg = idle && dbg_req && (!alu_req || starved);
    assign grant_alu = idle && alu_req && !grant_dbg;

    // Counts every losing cycle, including the busy ones, so a steady ALU stream cannot starve debug.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!dbg_req || grant_dbg) begin
            starve_cnt <= '0;
        end else if (!starved) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/flag_reg_ctrl.sv
// Sequences masked ALU updates and debug restores into the 3-bit flag register, forwarding to branch.
// Latency: full/zero mask commits 1 cycle after accept; partial mask 2 cycles (read-modify-write).
// Backpressure: ready only in IDLE; requesters hold req and data until their ack pulse.
module flag_reg_ctrl import flag_pkg::*; #(
    parameter int STARVE_LIMIT = 4,
    parameter int FLAG_W       = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_req,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic [FLAG_W-1:0] alu_mask,
    output logic              alu_ready,
    output logic              alu_ack,
    input  logic              dbg_req,
    input  logic [FLAG_W-1:0] dbg_flags,
    output logic              dbg_ready,
    output logic              dbg_ack,
    input  logic              br_rd,
    output logic [FLAG_W-1:0] br_flags,
    output logic              flags_pending,
    output logic [FLAG_W-1:0] reg_D,
    output logic              reg_WriteReg,
    output logic              reg_ReadEnable1,
    output logic              reg_ReadEnable2,
    input  logic [FLAG_W-1:0] reg_Bitline1,
    input  logic [FLAG_W-1:0] reg_Bitline2
);

    state_t            state;
    src_t              src_q;
    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] mask_q;
    logic [FLAG_W-1:0] old_q;
    logic              idle;
    logic              grant_alu;
    logic              grant_dbg;
    logic [FLAG_W-1:0] mask_in;
    logic [FLAG_W-1:0] flags_in;

    assign idle     = (state == IDLE);
    assign mask_in  = grant_dbg ? '1 : alu_mask;
    assign flags_in = grant_dbg ? dbg_flags : alu_flags;

    flag_arb #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .idle      (idle),
        .alu_req   (alu_req),
        .dbg_req   (dbg_req),
        .grant_alu (grant_alu),
        .grant_dbg (grant_dbg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            src_q   <= SRC_ALU;
            flags_q <= '0;
            mask_q  <= '0;
            old_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_alu || grant_dbg) begin
                        src_q   <= grant_dbg ? SRC_DBG : SRC_ALU;
                        flags_q <= flags_in;
                        mask_q  <= mask_in;
                        // Only a partial mask needs the old value; all-or-nothing masks skip READ.
                        state   <= ((mask_in != '0) && (mask_in != '1)) ? READ : WRITE;
                    end
                end
                READ: begin
                    old_q <= reg_Bitline1;
                    state <= WRITE;
                end
                WRITE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign alu_ready       = idle;
    assign dbg_ready       = idle;
    assign alu_ack         = (state == WRITE) && (src_q == SRC_ALU);
    assign dbg_ack         = (state == WRITE) && (src_q == SRC_DBG);
    assign reg_ReadEnable1 = (state == READ);
    assign reg_WriteReg    = (state == WRITE) && (mask_q != '0);
    assign reg_D           = (state == WRITE) ? merge_flags(old_q, flags_q, mask_q) : '0;
    assign flags_pending   = !idle || grant_alu || grant_dbg;

    // Bitline2 still shows the old value during a write cycle, so forward the data being written.
    assign reg_ReadEnable2 = br_rd;
    assign br_flags        = !br_rd       ? '0    :
                             reg_WriteReg ? reg_D : reg_Bitline2;

endmodule
